// File: rtl/char_ram_arbiter_pkg.sv
// Shared definitions for the character RAM arbiter: arbiter state encoding,
// default bus widths and the 800x525 VGA timing constants the sizes derive from.
package char_ram_arbiter_pkg;

  // Default widths: 80x30 character cells, 8-bit character codes
  localparam int ADDR_W_DEF       = 12;
  localparam int DATA_W_DEF       = 8;
  localparam int FIFO_DEPTH_DEF   = 4;

  // 800x525 VGA frame timing
  localparam int H_TOTAL          = 800;
  localparam int H_ACTIVE         = 640;
  localparam int V_TOTAL          = 525;
  localparam int V_ACTIVE         = 480;

  // A queued write may wait at most two full scan lines
  localparam int STARVE_LIMIT_DEF = 2 * H_TOTAL;

  // Arbiter states
  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,  // scan-out: display reads only
    S_BLANK  = 2'd1,  // blanking: reads first, otherwise drain one write
    S_FORCE  = 2'd2   // single-cycle forced write of the queue head
  } arb_state_e;

endpackage

// File: rtl/char_ram_arbiter_wr_fifo.sv
// Small synchronous write queue holding {address, data} pairs for the
// character RAM. Push is ignored while full, pop is ignored while empty.
module char_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers and fill level; pointers wrap naturally since DEPTH is a power of two
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Entry storage
  // NOTE: storage is deliberately not reset; the level counter alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/char_ram_arbiter.sv
// Shares one single-port synchronous character RAM between the display read
// path (strict priority) and a queued write path drained during blanking,
// with a starvation guard that forces a write through after a long wait.
module char_ram_arbiter
  import char_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          video_on,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic                          rd_miss,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          starve_flag
);

  localparam int CNT_W = $clog2(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  arb_state_e                 state_q, state_d;
  logic                       run_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       rd_valid_q, rd_miss_q, starve_q;
  logic                       rd_gnt, wr_gnt, force_wr;
  logic                       push, fifo_full, fifo_empty;
  logic [ADDR_W+DATA_W-1:0]   head;
  logic [ADDR_W-1:0]          head_addr;
  logic [DATA_W-1:0]          head_data;

  // Nothing is granted or accepted until the first edge after reset releases
  assign wr_ready  = run_q && !fifo_full;
  assign push      = wr_valid && wr_ready;
  assign head_addr = head[DATA_W +: ADDR_W];
  assign head_data = head[DATA_W-1:0];

  char_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_wr_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({wr_addr, wr_data}),
    .pop_i       (wr_gnt),
    .head_o      (head),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Grant selection for the current cycle and next-state decision
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    rd_gnt   = 1'b0;
    wr_gnt   = 1'b0;
    force_wr = 1'b0;
    state_d  = video_on ? S_ACTIVE : S_BLANK;

    if (run_q) begin
      case (state_q)
        S_ACTIVE: rd_gnt = rd_req;
        S_BLANK: begin
          if (rd_req)           rd_gnt = 1'b1;
          else if (!fifo_empty) wr_gnt = 1'b1;
        end
        S_FORCE: begin
          // The head goes out even if the display is asking this cycle
          if (!fifo_empty) begin
            wr_gnt   = 1'b1;
            force_wr = 1'b1;
          end else begin
            rd_gnt   = rd_req;
          end
        end
        default: ;
      endcase
    end

    // Force is a single cycle; it is re-armed only by a fresh count
    if (state_q != S_FORCE && cnt_q == CNT_MAX && !fifo_empty) state_d = S_FORCE;
  end

  // Starvation counter: counts waiting cycles, clears on pop or empty queue, saturates
  always_comb begin
    cnt_d = cnt_q;
    if (fifo_empty || wr_gnt) cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // RAM port driven straight from the current grant
  always_comb begin
    ram_en    = rd_gnt || wr_gnt;
    ram_we    = wr_gnt;
    ram_addr  = '0;
    ram_wdata = '0;
    if (wr_gnt) begin
      ram_addr  = head_addr;
      ram_wdata = head_data;
    end else if (rd_gnt) begin
      ram_addr  = rd_addr;
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_BLANK;
    else       state_q <= state_d;
  end

  // Run enable, starvation count and one-cycle-late read response flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q      <= 1'b0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      starve_q   <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_gnt;
      rd_miss_q  <= force_wr && rd_req;
      starve_q   <= starve_q || force_wr;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_miss     = rd_miss_q;
  assign rd_data     = rd_valid_q ? ram_rdata : '0;
  assign starve_flag = starve_q;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Randomized bench for char_ram_arbiter against a queue-based behavioural model,
// with directed segments for queueing, draining, full FIFO, read latency,
// starvation forcing and asynchronous reset.
module tb_char_ram_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LIMIT = 1600;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          video_on = 1'b0, rd_req = 1'b0, wr_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] rd_data, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic          rd_valid, rd_miss, wr_ready, ram_en, ram_we, starve_flag;
  logic [2:0]    fifo_level;

  int n_vec = 0;
  int n_err = 0;

  char_ram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .video_on    (video_on),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_miss     (rd_miss),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .fifo_level  (fifo_level),
    .starve_flag (starve_flag)
  );

  always #5 clk = ~clk;

  // Environment RAM: single port, one-cycle read latency
  logic [DW-1:0] stub_mem [1 << AW];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) stub_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= stub_mem[ram_addr];
    end
  end

  // Behavioural model state
  logic [DW-1:0] model_mem [1 << AW];
  wr_t           mq[$];
  int            m_wait;
  bit            m_force, m_video, m_run, m_starve;
  bit            pend_v, pend_miss;
  logic [DW-1:0] pend_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_wait = 0; m_force = 0; m_video = 0; m_run = 0; m_starve = 0;
    pend_v = 0; pend_miss = 0; pend_data = '0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, advance the model
  task automatic step(input logic v, input logic rq, input logic [AW-1:0] ra,
                      input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit  rg, wg, fw, exp_ready, go_force;
    int  lvl;
    wr_t e;
    @(negedge clk);
    video_on = v; rd_req = rq; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    #1;
    lvl = mq.size();
    rg = 0; wg = 0; fw = 0;
    if (m_run) begin
      if (m_force && lvl > 0) begin wg = 1; fw = 1; end
      else if (m_force || m_video) rg = rq;
      else if (rq)      rg = 1;
      else if (lvl > 0) wg = 1;
    end
    exp_ready = m_run && (lvl < DEPTH);

    check("ram_en",      ram_en,      rg || wg);
    check("ram_we",      ram_we,      wg);
    if (wg) begin
      check("wr_addr_out", ram_addr,  mq[0].addr);
      check("wr_data_out", ram_wdata, mq[0].data);
    end else if (rg) begin
      check("rd_addr_out", ram_addr,  ra);
    end
    check("rd_valid",    rd_valid,    pend_v);
    check("rd_miss",     rd_miss,     pend_miss);
    if (pend_v) check("rd_data", rd_data, pend_data);
    check("wr_ready",    wr_ready,    exp_ready);
    check("fifo_level",  fifo_level,  lvl);
    check("starve_flag", starve_flag, m_starve);

    // Model update for the coming rising edge
    go_force = !m_force && (m_wait == LIMIT - 1) && (lvl > 0);
    if (wg) begin
      e = mq.pop_front();
      model_mem[e.addr] = e.data;
    end
    if (wv && exp_ready) mq.push_back('{addr: wa, data: wd});
    if (lvl == 0 || wg)         m_wait = 0;
    else if (m_wait < LIMIT - 1) m_wait = m_wait + 1;
    pend_v    = rg;
    pend_data = rg ? model_mem[ra] : '0;
    pend_miss = fw && rq;
    m_starve  = m_starve || fw;
    m_force   = go_force;
    m_video   = v;
  endtask

  // Entered with reset already high: verify outputs are cleared, then release
  task automatic hold_reset(input string tag);
    model_clear();
    #1;
    check({tag, "_lvl"},      fifo_level, 0);
    check({tag, "_rd_valid"}, rd_valid,   0);
    check({tag, "_rd_miss"},  rd_miss,    0);
    check({tag, "_ram_en"},   ram_en,     0);
    check({tag, "_ram_we"},   ram_we,     0);
    check({tag, "_ram_addr"}, ram_addr,   0);
    check({tag, "_rd_data"},  rd_data,    0);
    check({tag, "_wr_ready"}, wr_ready,   0);
    check({tag, "_starve"},   starve_flag, 0);
    repeat (2) @(negedge clk);
    check({tag, "_held_ready"}, wr_ready, 0);
    reset = 1'b0;
    #1;
    check({tag, "_rel_ready"},  wr_ready, 0);
    check({tag, "_rel_ram_en"}, ram_en,   0);
    // The next rising edge only arms the arbiter
    m_run   = 1;
    m_video = video_on;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      stub_mem[i]  = DW'($urandom);
      model_mem[i] = stub_mem[i];
    end
    stub_mem[12'h012]  = 8'h41;
    model_mem[12'h012] = 8'h41;

    hold_reset("rst0");

    // Three writes queued during scan-out while the display reads every cycle
    for (int i = 0; i < 3; i++) step(1, 1, AW'($urandom), 1, AW'(12'h100 + i), DW'(8'hA0 + i));
    step(1, 1, AW'($urandom), 0, '0, '0);
    check("queued3_level", fifo_level, 3);

    // Blanking with no reads drains them in push order
    for (int i = 0; i < 5; i++) step(0, 0, '0, 0, '0, '0);
    check("drained_level", fifo_level, 0);

    // Fill the queue during scan-out; the fifth and sixth offers are refused
    for (int i = 0; i < 6; i++) step(1, 0, '0, 1, AW'(12'h200 + i), DW'($urandom));
    check("full_ready", wr_ready, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0, '0);
    check("after_pop_ready", wr_ready, 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, '0, '0);

    // Read with one-cycle latency
    step(0, 1, 12'h012, 0, '0, '0);
    step(0, 0, '0, 0, '0, '0);
    check("read_0x012_valid", rd_valid, 1);
    check("read_0x012_data",  rd_data,  8'h41);

    // Starvation: one write waits behind continuous scan-out reads
    step(1, 1, AW'($urandom), 1, 12'h300, 8'h5A);
    for (int i = 0; i < 1700; i++) step(1, 1, AW'($urandom), 0, '0, '0);
    check("starve_seen", starve_flag, 1);

    // Random traffic following a line-like video_on pattern
    for (int c = 0; c < 3000; c++) begin
      logic v, rq, wv;
      v  = (c % 800) < 600;
      rq = v ? ($urandom_range(9) < 8) : ($urandom_range(9) < 3);
      wv = $urandom_range(9) < 4;
      step(v, rq, AW'($urandom), wv, AW'($urandom), DW'($urandom));
    end

    // Reset mid-operation: two writes queued and a read in flight
    for (int i = 0; i < 8; i++) step(0, 0, '0, 0, '0, '0);
    step(1, 1, AW'($urandom), 1, AW'($urandom), DW'($urandom));
    step(1, 1, AW'($urandom), 1, AW'($urandom), DW'($urandom));
    step(1, 1, AW'($urandom), 0, '0, '0);
    check("pre_rst_level", fifo_level, 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    hold_reset("rst1");

    // Traffic after the mid-run reset
    for (int c = 0; c < 300; c++) begin
      step(1'($urandom), 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
